// File: rtl/apb_event_ctrl_pkg.sv
// apb_event_ctrl_pkg: register byte offsets and interrupt FSM state type
package apb_event_ctrl_pkg;
    localparam logic [5:0] OFF_IRQ_ENABLE  = 6'h00;
    localparam logic [5:0] OFF_IRQ_PENDING = 6'h04;
    localparam logic [5:0] OFF_IRQ_SET     = 6'h08;
    localparam logic [5:0] OFF_IRQ_CLR     = 6'h0C;
    localparam logic [5:0] OFF_IRQ_ID      = 6'h10;
    localparam logic [5:0] OFF_IRQ_EOI     = 6'h14;
    localparam logic [5:0] OFF_EVT_ENABLE  = 6'h18;
    localparam logic [5:0] OFF_EVT_PENDING = 6'h1C;
    localparam logic [5:0] OFF_SLEEP       = 6'h20;
    localparam logic [5:0] OFF_STATUS      = 6'h24;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2
    } irq_state_e;
endpackage

// File: rtl/apb_event_prio_enc.sv
// apb_event_prio_enc: highest set index of a vector plus valid flag
//   vec_i   in  W  request vector
//   idx_o   out 5  index of highest set bit (0 when none)
//   valid_o out 1  any bit set
module apb_event_prio_enc #(
    parameter int W = 32
) (
    input  logic [W-1:0] vec_i,
    output logic [4:0]   idx_o,
    output logic         valid_o
);
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) idx_o = vec_i[i] ? 5'(i) : idx_o;
    end
    assign valid_o = |vec_i;
endmodule

// File: rtl/apb_event_ctrl.sv
// apb_event_ctrl: APB interrupt/event controller with core sleep/wake control
//   HCLK/HRESET            clock, synchronous active-high reset
//   PADDR..PSLVERR         APB slave, single-cycle access
//   irq_i, event_i         interrupt sources, level wake events
//   irq_ack_i/irq_o/irq_id_o  request handshake with the core
//   fetch_enable_o         core run (1) / sleep (0)
module apb_event_ctrl
    import apb_event_ctrl_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_IRQ        = 32,
    parameter int NUM_EVT        = 32,
    parameter int IRQ_EDGE       = 1,
    parameter int FETCH_EN_RST   = 1
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_IRQ-1:0]        irq_i,
    input  logic [NUM_EVT-1:0]        event_i,
    input  logic                      irq_ack_i,
    output logic                      irq_o,
    output logic [4:0]                irq_id_o,
    output logic                      fetch_enable_o
);
    logic [NUM_IRQ-1:0] irq_en_q, irq_en_d, irq_pend_q, irq_pend_d, irq_prev_q, irq_set, irq_wd;
    logic [NUM_EVT-1:0] evt_en_q, evt_en_d, evt_pend_q, evt_pend_d, evt_wd;
    irq_state_e         state_q, state_d;
    logic [4:0]         irq_id_q, irq_id_d, enc_idx;
    logic               fetch_en_q, fetch_en_d, enc_valid, acc, err, wr, wake;
    logic [5:0]         off;

    assign acc     = PSEL & PENABLE & ~HRESET;
    assign err     = PADDR > APB_ADDR_WIDTH'(OFF_STATUS);
    assign off     = {PADDR[5:2], 2'b00};
    assign wr      = acc & PWRITE & ~err;
    assign irq_wd  = PWDATA[NUM_IRQ-1:0];
    assign evt_wd  = PWDATA[NUM_EVT-1:0];
    assign irq_set = (IRQ_EDGE != 0) ? (irq_i & ~irq_prev_q & irq_en_q) : (irq_i & irq_en_q);
    // A request in flight counts as a wake source so the core runs to take it
    assign wake    = (|(evt_pend_q & evt_en_q)) | (state_q == ST_REQ);

    apb_event_prio_enc #(.W(NUM_IRQ)) u_enc (
        .vec_i   (irq_pend_q & irq_en_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        irq_en_d   = (wr && off == OFF_IRQ_ENABLE) ? irq_wd : irq_en_q;
        evt_en_d   = (wr && off == OFF_EVT_ENABLE) ? evt_wd : evt_en_q;
        irq_pend_d = (wr && off == OFF_IRQ_PENDING) ? irq_wd : irq_pend_q;
        irq_pend_d = (wr && off == OFF_IRQ_SET) ? (irq_pend_d | irq_wd) : irq_pend_d;
        irq_pend_d = (wr && off == OFF_IRQ_CLR) ? (irq_pend_d & ~irq_wd) : irq_pend_d;
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        if (state_q == ST_IDLE && enc_valid) begin
            state_d    = ST_REQ;
            irq_id_d   = enc_idx;
            irq_pend_d = irq_pend_d & ~(NUM_IRQ'(1) << enc_idx);
        end else if (state_q == ST_REQ && irq_ack_i) begin
            state_d = ST_SERVE;
        end else if (state_q == ST_SERVE && wr && off == OFF_IRQ_EOI) begin
            state_d = ST_IDLE;
        end
        // Hardware set applied last so it beats any clear of the same bit
        irq_pend_d = irq_pend_d | irq_set;
        evt_pend_d = ((wr && off == OFF_EVT_PENDING) ? (evt_pend_q & ~evt_wd) : evt_pend_q) | (event_i & evt_en_q);
        fetch_en_d = wake | ((wr && off == OFF_SLEEP) ? ~PWDATA[0] : fetch_en_q);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_en_q   <= '0;
            irq_pend_q <= '0;
            irq_prev_q <= '0;
            evt_en_q   <= '0;
            evt_pend_q <= '0;
            state_q    <= ST_IDLE;
            irq_id_q   <= '0;
            fetch_en_q <= 1'(FETCH_EN_RST);
        end else begin
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            irq_prev_q <= irq_i;
            evt_en_q   <= evt_en_d;
            evt_pend_q <= evt_pend_d;
            state_q    <= state_d;
            irq_id_q   <= irq_id_d;
            fetch_en_q <= fetch_en_d;
        end
    end

    // IRQ_ID bit31 flags that the latched id is being serviced
    always_comb begin
        PRDATA = '0;
        if (acc && !PWRITE && !err) begin
            case (off)
                OFF_IRQ_ENABLE:  PRDATA = 32'(irq_en_q);
                OFF_IRQ_PENDING: PRDATA = 32'(irq_pend_q);
                OFF_IRQ_ID:      PRDATA = {state_q == ST_SERVE, 26'd0, irq_id_q};
                OFF_EVT_ENABLE:  PRDATA = 32'(evt_en_q);
                OFF_EVT_PENDING: PRDATA = 32'(evt_pend_q);
                OFF_STATUS:      PRDATA = {29'd0, fetch_en_q, state_q};
                default:         PRDATA = '0;
            endcase
        end
    end

    assign PREADY         = 1'b1;
    assign PSLVERR        = acc & err;
    assign irq_o          = state_q == ST_REQ;
    assign irq_id_o       = irq_id_q;
    assign fetch_enable_o = fetch_en_q;
endmodule

// File: tb/tb_apb_event_ctrl.sv
// tb_apb_event_ctrl: directed and randomized checks of apb_event_ctrl against a behavioural model
module tb_apb_event_ctrl;
    localparam int NI = 8;
    localparam int NE = 16;
    localparam int unsigned IM = 32'h0000_00FF;
    localparam int unsigned EM = 32'h0000_FFFF;

    logic          HCLK = 1'b0;
    logic          HRESET, PWRITE, PSEL, PENABLE, PREADY, PSLVERR, irq_ack_i, irq_o, fetch_enable_o;
    logic [11:0]   PADDR;
    logic [31:0]   PWDATA, PRDATA;
    logic [NI-1:0] irq_i;
    logic [NE-1:0] event_i;
    logic [4:0]    irq_id_o;
    int            checks = 0;
    int            errors = 0;

    int unsigned m_en, m_pend, m_een, m_epend, m_prev, m_id;
    int          m_st;
    bit          m_fe;

    apb_event_ctrl #(.APB_ADDR_WIDTH(12), .NUM_IRQ(NI), .NUM_EVT(NE), .IRQ_EDGE(1), .FETCH_EN_RST(1)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_i(irq_i),
        .event_i(event_i), .irq_ack_i(irq_ack_i), .irq_o(irq_o), .irq_id_o(irq_id_o),
        .fetch_enable_o(fetch_enable_o)
    );

    always #5 HCLK = ~HCLK;

    function automatic int highest(int unsigned v);
        for (int i = 31; i >= 0; i--) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int unsigned mread(int unsigned a);
        if (a > 'h24) return 0;
        case (a & 'h3C)
            'h00: return m_en;
            'h04: return m_pend;
            'h10: return (m_st == 2 ? 32'h8000_0000 : 32'h0) | m_id;
            'h18: return m_een;
            'h1C: return m_epend;
            'h24: return 32'(m_st) | (m_fe ? 32'h4 : 32'h0);
            default: return 0;
        endcase
    endfunction

    // Advances one clock and evolves the model from the inputs seen at that edge
    task automatic tick();
        int unsigned a, w, rise, en, pend, een, ep, id;
        int st;
        bit fe, wr, rst;
        rst  = HRESET;
        a    = 32'({PADDR[5:2], 2'b00});
        w    = PWDATA;
        wr   = PSEL && PENABLE && PWRITE && (PADDR <= 12'h24);
        en = m_en; pend = m_pend; een = m_een; ep = m_epend; id = m_id; st = m_st; fe = m_fe;
        rise = 32'(irq_i) & ~m_prev & m_en;
        if (wr && a == 'h00) en = w & IM;
        if (wr && a == 'h04) pend = w & IM;
        if (wr && a == 'h08) pend |= w & IM;
        if (wr && a == 'h0C) pend &= ~w;
        if (wr && a == 'h18) een = w & EM;
        if (wr && a == 'h1C) ep &= ~w;
        if (m_st == 0 && (m_pend & m_en) != 0) begin
            id = highest(m_pend & m_en);
            pend &= ~(32'd1 << id);
            st = 1;
        end else if (m_st == 1 && irq_ack_i) st = 2;
        else if (m_st == 2 && wr && a == 'h14) st = 0;
        pend = (pend | rise) & IM;
        ep = (ep | (32'(event_i) & m_een)) & EM;
        if (wr && a == 'h20) fe = !PWDATA[0];
        if ((m_epend & m_een) != 0 || m_st == 1) fe = 1;
        @(posedge HCLK);
        if (rst) begin
            m_en = 0; m_pend = 0; m_een = 0; m_epend = 0; m_id = 0; m_st = 0; m_fe = 1; m_prev = 0;
        end else begin
            m_en = en; m_pend = pend; m_een = een; m_epend = ep; m_id = id; m_st = st; m_fe = fe;
            m_prev = 32'(irq_i);
        end
        #1;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1;
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        tick();
        PENABLE = 1;
        #1;
        d = PRDATA;
        e = PSLVERR;
        tick();
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic e;
        HRESET = 1;
        tick(); tick();
        PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = 12'h28;
        #1;
        checks++; if (PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin errors++; $display("FAIL rst_access prdata=%h pslverr=%b want 0/0", PRDATA, PSLVERR); end
        PWRITE = 1; PADDR = 12'h0; PWDATA = 32'hFF;
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0; HRESET = 0;
        tick();
        checks++; if (irq_o !== 1'b0 || irq_id_o !== 5'd0) begin errors++; $display("FAIL rst_irq irq_o=%b id=%0d want 0/0", irq_o, irq_id_o); end
        checks++; if (fetch_enable_o !== 1'b1) begin errors++; $display("FAIL rst_fetch got=%b want 1", fetch_enable_o); end
        checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL pready got=%b want 1", PREADY); end
        apb_rd(12'h24, d, e);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL rst_status got=%h want 4", d); end
        apb_rd(12'h00, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_enable got=%h want 0", d); end
    endtask

    task automatic test_dispatch();
        logic [31:0] d;
        logic e;
        apb_wr(12'h00, 32'h5);
        irq_i = 8'h05;
        tick();
        irq_i = 8'h00;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL disp_early irq_o=%b want 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 5'd2) begin errors++; $display("FAIL disp_first irq_o=%b id=%0d want 1/2", irq_o, irq_id_o); end
        apb_rd(12'h04, d, e);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL disp_pending got=%h want 1", d); end
        apb_rd(12'h10, d, e);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL disp_id_req got=%h want 2", d); end
        irq_ack_i = 1;
        tick();
        irq_ack_i = 0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL disp_ack irq_o=%b want 0", irq_o); end
        apb_rd(12'h24, d, e);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL disp_serve_status got=%h want 6", d); end
        apb_rd(12'h10, d, e);
        checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL disp_id_serve got=%h want 80000002", d); end
        apb_wr(12'h14, 32'h0);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL disp_gap irq_o=%b want 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 5'd0) begin errors++; $display("FAIL disp_second irq_o=%b id=%0d want 1/0", irq_o, irq_id_o); end
        irq_ack_i = 1;
        tick();
        irq_ack_i = 0;
        apb_wr(12'h14, 32'h0);
        apb_rd(12'h04, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL disp_drain got=%h want 0", d); end
        apb_wr(12'h00, 32'h0);
    endtask

    task automatic test_edge_hold();
        logic [31:0] d;
        logic e;
        int rises = 0;
        logic last = 0;
        apb_wr(12'h00, 32'h8);
        irq_i = 8'h08;
        irq_ack_i = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (irq_o && !last) rises++;
            last = irq_o;
        end
        irq_i = 0;
        irq_ack_i = 0;
        checks++; if (irq_id_o !== 5'd3) begin errors++; $display("FAIL edge_id got=%0d want 3", irq_id_o); end
        apb_wr(12'h14, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (irq_o && !last) rises++;
            last = irq_o;
        end
        checks++; if (rises !== 1) begin errors++; $display("FAIL edge_dispatches got=%0d want 1", rises); end
        apb_rd(12'h04, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_pending got=%h want 0", d); end
        apb_wr(12'h00, 32'h0);
    endtask

    task automatic test_hw_wins();
        apb_wr(12'h00, 32'h2);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 12'h0C; PWDATA = 32'h2;
        tick();
        PENABLE = 1; irq_i = 8'h02;
        tick();
        PWRITE = 0; PADDR = 12'h04;
        #1;
        checks++; if (PRDATA !== 32'h2) begin errors++; $display("FAIL hw_wins pending=%h want 2", PRDATA); end
        tick();
        PSEL = 0; PENABLE = 0; irq_i = 0;
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 5'd1) begin errors++; $display("FAIL hw_wins_disp irq_o=%b id=%0d want 1/1", irq_o, irq_id_o); end
        irq_ack_i = 1;
        tick();
        irq_ack_i = 0;
        apb_wr(12'h14, 32'h0);
        apb_wr(12'h00, 32'h0);
    endtask

    task automatic test_sleep_wake();
        logic [31:0] d;
        logic e;
        apb_wr(12'h18, 32'h10);
        apb_wr(12'h20, 32'h1);
        checks++; if (fetch_enable_o !== 1'b0) begin errors++; $display("FAIL sleep got=%b want 0", fetch_enable_o); end
        event_i = 16'h0010;
        tick();
        event_i = 0;
        checks++; if (fetch_enable_o !== 1'b0) begin errors++; $display("FAIL wake_early got=%b want 0", fetch_enable_o); end
        tick();
        checks++; if (fetch_enable_o !== 1'b1) begin errors++; $display("FAIL wake got=%b want 1", fetch_enable_o); end
        apb_rd(12'h1C, d, e);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL evt_pending got=%h want 10", d); end
        apb_wr(12'h20, 32'h1);
        checks++; if (fetch_enable_o !== 1'b1) begin errors++; $display("FAIL wake_beats_sleep got=%b want 1", fetch_enable_o); end
        apb_wr(12'h1C, 32'h10);
        apb_rd(12'h1C, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL evt_w1c got=%h want 0", d); end
        apb_wr(12'h20, 32'h1);
        checks++; if (fetch_enable_o !== 1'b0) begin errors++; $display("FAIL resleep got=%b want 0", fetch_enable_o); end
        apb_wr(12'h20, 32'h0);
        checks++; if (fetch_enable_o !== 1'b1) begin errors++; $display("FAIL unsleep got=%b want 1", fetch_enable_o); end
        apb_wr(12'h18, 32'h0);
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic e;
        apb_rd(12'h28, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_read pslverr=%b prdata=%h want 1/0", e, d); end
        apb_wr(12'h00, 32'h3);
        apb_wr(12'h40, 32'hFFFF);
        apb_rd(12'h00, d, e);
        checks++; if (d !== 32'h3 || e !== 1'b0) begin errors++; $display("FAIL err_nowrite got=%h/%b want 3/0", d, e); end
        apb_wr(12'h00, 32'hFFFF);
        apb_rd(12'h00, d, e);
        checks++; if (d !== 32'hFF) begin errors++; $display("FAIL irq_width got=%h want ff", d); end
        apb_wr(12'h18, 32'hFFFF_FFFF);
        apb_rd(12'h18, d, e);
        checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL evt_width got=%h want ffff", d); end
        apb_wr(12'h00, 32'h0);
        apb_wr(12'h18, 32'h0);
    endtask

    task automatic test_reset_serve();
        logic [31:0] d;
        logic e;
        apb_wr(12'h18, 32'h3);
        apb_wr(12'h00, 32'h1);
        apb_wr(12'h08, 32'h80);
        irq_i = 8'h01;
        tick();
        irq_i = 0;
        tick();
        irq_ack_i = 1;
        tick();
        irq_ack_i = 0;
        apb_rd(12'h24, d, e);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL pre_rst_status got=%h want 6", d); end
        HRESET = 1;
        tick();
        HRESET = 0;
        checks++; if (irq_o !== 1'b0 || irq_id_o !== 5'd0 || fetch_enable_o !== 1'b1) begin errors++; $display("FAIL rst_serve_out irq_o=%b id=%0d fe=%b want 0/0/1", irq_o, irq_id_o, fetch_enable_o); end
        apb_rd(12'h24, d, e);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL rst_serve_status got=%h want 4", d); end
        apb_rd(12'h04, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_serve_pending got=%h want 0", d); end
        apb_rd(12'h18, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_serve_evt_en got=%h want 0", d); end
        apb_rd(12'h00, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_serve_enable got=%h want 0", d); end
    endtask

    task automatic test_random();
        logic [11:0] addrs [11] = '{12'h00, 12'h04, 12'h08, 12'h0C, 12'h10, 12'h14, 12'h18, 12'h1C, 12'h20, 12'h24, 12'h28};
        int unsigned want_rd;
        logic want_err;
        for (int n = 0; n < 600; n++) begin
            irq_i     = NI'($urandom);
            event_i   = ($urandom_range(0, 7) == 0) ? NE'($urandom) : '0;
            irq_ack_i = 1'($urandom);
            PSEL      = 1'($urandom);
            PENABLE   = PSEL;
            PWRITE    = 1'($urandom);
            PADDR     = addrs[$urandom_range(0, 10)];
            PWDATA    = $urandom;
            #1;
            want_rd  = (PSEL && PENABLE && !PWRITE) ? mread(32'(PADDR)) : 0;
            want_err = PSEL && PENABLE && (PADDR > 12'h24);
            checks++; if (PRDATA !== want_rd || PSLVERR !== want_err) begin errors++; $display("FAIL rnd_apb addr=%h prdata=%h pslverr=%b want %h/%b", PADDR, PRDATA, PSLVERR, want_rd, want_err); end
            tick();
            checks++; if (irq_o !== (m_st == 1) || irq_id_o !== 5'(m_id) || fetch_enable_o !== m_fe) begin errors++; $display("FAIL rnd_out cyc=%0d irq_o=%b id=%0d fe=%b want %b/%0d/%b", n, irq_o, irq_id_o, fetch_enable_o, m_st == 1, m_id, m_fe); end
        end
        PSEL = 0; PENABLE = 0; irq_i = 0; event_i = 0; irq_ack_i = 0;
    endtask

    initial begin
        HRESET = 1; PADDR = 0; PWDATA = 0; PWRITE = 0; PSEL = 0; PENABLE = 0;
        irq_i = 0; event_i = 0; irq_ack_i = 0;
        m_en = 0; m_pend = 0; m_een = 0; m_epend = 0; m_prev = 0; m_id = 0; m_st = 0; m_fe = 1;
        test_reset();
        test_dispatch();
        test_edge_hold();
        test_hw_wins();
        test_sleep_wake();
        test_errors();
        test_reset_serve();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
